// File: rtl/maze_pkg.sv
// Shared types and default constants for the down-counting timer.
package maze_pkg;

  // Timer operating states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } timer_state_t;

  // Default counter width and clock cycles per decrement.
  localparam int unsigned DEFAULT_WIDTH    = 12;
  localparam int unsigned DEFAULT_TICK_DIV = 50000000;

  // Bits needed to hold prescaler values 0..div-1.
  // The result is never below one bit.
  function automatic int unsigned prescaler_width(input int unsigned div);
    return (div <= 32'd2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that counts 0..TICK_DIV-1 while enabled.
// Tick marks the terminal value. The wrap happens on the next enabled edge.
module tick_prescaler
  import maze_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic En,
  input  logic Clr,
  output logic Tick
);

  localparam int unsigned PW = prescaler_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Tick is decoded from the register alone, so the consumer can gate it
  // with its own enable without forming a combinational loop.
  assign Tick = (cnt_q == LAST);

  // Next prescaler value: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (En) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/down_timer_12.sv
// Loadable down-counter with a start/pause/expire FSM.
// The decrement rate is set by a tick_prescaler instance.
module down_timer_12
  import maze_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic             Start,
  input  logic             Pause,
  input  logic [WIDTH-1:0] Start_Val,
  output logic [WIDTH-1:0] Count_Out,
  output logic             Running,
  output logic             Expired,
  output logic             Expire_Pulse
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             running_q, expired_q, pulse_q, pulse_d;
  logic             presc_en, presc_clr, presc_tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .En      (presc_en),
    .Clr     (presc_clr),
    .Tick    (presc_tick)
  );

  // Next state, next count and prescaler control.
  // Load overrides everything. Pause beats a same-cycle terminal tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pulse_d   = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;

    if (Load) begin
      count_d   = Start_Val;
      state_d   = ST_IDLE;
      presc_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Keep the prescaler at zero so the first decrement lands
          // exactly TICK_DIV cycles after the Start edge.
          presc_clr = 1'b1;
          if (Start) begin
            if (count_q == '0) begin
              state_d = ST_DONE;
              pulse_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (Pause) begin
            state_d = ST_PAUSED;
          end else begin
            presc_en = 1'b1;
            if (presc_tick && (count_q != '0)) begin
              count_d = count_q - WIDTH'(1);
              if (count_q == WIDTH'(1)) begin
                state_d = ST_DONE;
                pulse_d = 1'b1;
              end
            end
          end
        end

        ST_PAUSED: begin
          // The prescaler holds its value, so a resume continues the current period.
          if (Start && !Pause) begin
            state_d = ST_RUN;
          end
        end

        ST_DONE: begin
          // Only Load or reset leaves DONE.
          count_d = '0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, count and registered status outputs, all taken from next-state values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_DONE);
      pulse_q   <= pulse_d;
    end
  end

  assign Count_Out    = count_q;
  assign Running      = running_q;
  assign Expired      = expired_q;
  assign Expire_Pulse = pulse_q;

endmodule

// File: tb/tb_down_timer_12.sv
// Self-checking bench for down_timer_12 with TICK_DIV=4.
// It runs directed scenarios, then a randomized run.
// The reference model tracks the loaded value and the enabled cycles elapsed since the load.
module tb_down_timer_12;

  localparam int W   = 12;
  localparam int DIV = 4;

  // Model modes, local to the bench.
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Load, Start, Pause;
  logic [W-1:0] Start_Val;
  logic [W-1:0] Count_Out;
  logic         Running, Expired, Expire_Pulse;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_loaded, m_elapsed, m_mode;
  bit m_pulse;

  down_timer_12 #(
    .WIDTH    (W),
    .TICK_DIV (DIV)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Load         (Load),
    .Start        (Start),
    .Pause        (Pause),
    .Start_Val    (Start_Val),
    .Count_Out    (Count_Out),
    .Running      (Running),
    .Expired      (Expired),
    .Expire_Pulse (Expire_Pulse)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The count equals the loaded value minus the number of completed prescaler periods.
  function automatic int m_count();
    return m_loaded - (m_elapsed / DIV);
  endfunction

  task automatic model_reset();
    m_loaded  = 0;
    m_elapsed = 0;
    m_mode    = M_IDLE;
    m_pulse   = 1'b0;
  endtask

  task automatic model_step(input bit ld, input bit st, input bit pa, input int sv);
    m_pulse = 1'b0;
    if (ld) begin
      m_loaded  = sv;
      m_elapsed = 0;
      m_mode    = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (st) begin
          if (m_count() == 0) begin
            m_mode  = M_DONE;
            m_pulse = 1'b1;
          end else begin
            m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (pa) begin
            m_mode = M_PAUSE;
          end else begin
            m_elapsed++;
            if (m_count() == 0) begin
              m_mode  = M_DONE;
              m_pulse = 1'b1;
            end
          end
        end
        M_PAUSE: if (st && !pa) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},   32'(Count_Out),    32'(m_count()));
    check({tag, ".running"}, 32'(Running),      32'(m_mode == M_RUN));
    check({tag, ".expired"}, 32'(Expired),      32'(m_mode == M_DONE));
    check({tag, ".pulse"},   32'(Expire_Pulse), 32'(m_pulse));
  endtask

  // Drive inputs (called at negedge), take one rising edge, then compare at the next falling edge.
  task automatic cycle(input bit ld, input bit st, input bit pa, input logic [W-1:0] sv,
                       input string tag);
    Load      = ld;
    Start     = st;
    Pause     = pa;
    Start_Val = sv;
    @(posedge Clk);
    model_step(ld, st, pa, int'(sv));
    @(negedge Clk);
    compare_all(tag);
  endtask

  // Assert reset between edges and check that the outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n   = 1'b0;
    Load      = 1'b0;
    Start     = 1'b0;
    Pause     = 1'b0;
    Start_Val = '0;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Start straight after reset with count 0: go to DONE with one pulse.
    cycle(0, 1, 0, 0, "r32a");
    check("r32_pulse", 32'(Expire_Pulse), 32'd1);
    check("r32_expired", 32'(Expired), 32'd1);
    cycle(0, 1, 1, 0, "r32b");
    check("r32_pulse_once", 32'(Expire_Pulse), 32'd0);
    check("r32_count", 32'(Count_Out), 32'd0);

    // Load 3 and start: the count steps down every 4 cycles.
    cycle(1, 0, 0, 3, "r29_load");
    cycle(0, 1, 0, 0, "r29_start");
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 0, 0, 0, "r29_run");
      check("r29_cnt", 32'(Count_Out), 32'(3 - k / 4));
      check("r29_pulse", 32'(Expire_Pulse), 32'(k == 12));
      check("r29_running", 32'(Running), 32'(k < 12));
    end
    cycle(0, 1, 1, 0, "r29_after");
    check("r29_expired_hold", 32'(Expired), 32'd1);

    // Load 5, pause after the first decrement, then resume.
    cycle(1, 0, 0, 5, "r30_load");
    cycle(0, 1, 0, 0, "r30_start");
    for (int k = 1; k <= 5; k++) cycle(0, 0, 0, 0, "r30_run1");
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 1, 0, "r30_pause");
      check("r30_hold", 32'(Count_Out), 32'd4);
    end
    cycle(0, 1, 0, 0, "r30_resume");
    for (int k = 1; k <= 15; k++) begin
      cycle(0, 0, 0, 0, "r30_run2");
      check("r30_pulse", 32'(Expire_Pulse), 32'(k == 15));
    end

    // A reload mid-run returns to IDLE without a pulse.
    cycle(1, 0, 0, 7, "r31_load");
    cycle(0, 1, 0, 0, "r31_start");
    for (int k = 1; k <= 4; k++) cycle(0, 0, 0, 0, "r31_run");
    cycle(1, 0, 0, 2, "r31_reload");
    check("r31_count", 32'(Count_Out), 32'd2);
    check("r31_running", 32'(Running), 32'd0);
    check("r31_pulse", 32'(Expire_Pulse), 32'd0);

    // Pause at the terminal tick (with Start also high) wins and blocks the decrement.
    cycle(1, 0, 0, 5, "r34_load");
    cycle(0, 1, 0, 0, "r34_start");
    for (int k = 1; k <= 3; k++) cycle(0, 0, 0, 0, "r34_run");
    cycle(0, 1, 1, 0, "r34_pause");
    check("r34_count", 32'(Count_Out), 32'd5);
    check("r34_running", 32'(Running), 32'd0);
    cycle(0, 1, 0, 0, "r34_resume");
    cycle(0, 0, 0, 0, "r34_tick");
    check("r34_dec", 32'(Count_Out), 32'd4);

    // Asynchronous reset mid-run aborts the countdown.
    cycle(1, 0, 0, 3, "r33_load");
    cycle(0, 1, 0, 0, "r33_start");
    for (int k = 1; k <= 5; k++) cycle(0, 0, 0, 0, "r33_run");
    async_reset("r33_rst");
    for (int k = 0; k < 16; k++) begin
      cycle(0, 0, 0, 0, "r33_idle");
      check("r33_nopulse", 32'(Expire_Pulse), 32'd0);
    end

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      bit ld, st, pa;
      logic [W-1:0] sv;
      ld = ($urandom_range(19) == 0);
      st = ($urandom_range(9) < 3);
      pa = ($urandom_range(9) < 2);
      sv = ($urandom_range(7) == 0) ? W'($urandom) : W'($urandom_range(9));
      if ($urandom_range(499) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cycle(ld, st, pa, sv, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
